thumb_fetch_unit: RTL and testbench
===================================

Name: thumb_fetch_unit

Overview:
Parametrised instruction fetch front-end for the Cortex-M0 core; replaces the single-register PC/MAR/IR fetch path. Issues 32-bit word reads to the program ROM and buffers halfwords in a circular prefetch queue. Presents one aligned Thumb instruction (16- or 32-bit) per handshake to decode. Supports branch redirect with flush, halfword-aligned targets, and fetch enable/halt.

Parameters:
ADDR_W, 16, byte address width of PC and ROM address
BUF_DEPTH, 8, prefetch queue depth in halfwords (power of 2, >= 4)
RESET_PC, 0, byte address fetched after reset (bit 0 ignored)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_en  in  1  permits new ROM requests; in-flight response still accepted when low
mem_req  out  1  ROM read request this cycle
mem_addr  out  ADDR_W  word-aligned byte address (bits [1:0]=0)
mem_rdata  in  32  ROM data; [15:0]=halfword at addr, [31:16]=halfword at addr+2
mem_rvalid  in  1  data valid, exactly 1 cycle after mem_req
redirect_valid  in  1  branch/exception redirect
redirect_addr  in  ADDR_W  target byte address (bit 0 ignored)
inst_valid  out  1  instruction available
inst_ready  in  1  decode accepts instruction
inst_data  out  32  [31:16]=first halfword, [15:0]=second halfword (0 for 16-bit)
inst_is32  out  1  instruction is 32-bit Thumb-2
inst_pc  out  ADDR_W  byte address of first halfword

Behaviour:
- Decided: reset rst, synchronous, active-high; clock clk.
- Reset: mem_req=0, inst_valid=0, queue count=0, head_pc=RESET_PC&~1, fetch_addr=RESET_PC&~3, skip_low=RESET_PC[1], state=S_IDLE.
- FSM: S_IDLE -> S_RUN when fetch_en. S_RUN -> S_IDLE when !fetch_en and no request in flight. Any state -> S_DROP on redirect_valid if a request is in flight, else -> S_RUN (or S_IDLE if !fetch_en). S_DROP: discards the one pending response, then -> S_RUN/S_IDLE.
- 32-bit detect: first halfword [15:11] in {11101,11110,11111}.
- Issue: mem_req=1 in S_RUN when fetch_en, !redirect_valid, and count + 2*inflight + 2 <= BUF_DEPTH. mem_addr=fetch_addr; fetch_addr += 4 on issue, wraps modulo 2^ADDR_W.
- Push on mem_rvalid (not in S_DROP): low halfword then high halfword. If skip_low set, push high only and clear skip_low.
- Output: inst_valid = count>=1 and head 16-bit, or count>=2. inst_data/inst_is32/inst_pc driven combinationally from queue head and head_pc.
- Pop on inst_valid&&inst_ready: 1 or 2 halfwords; head_pc += 2 or 4 (wraps). Push and pop in the same cycle are both applied.
- Redirect has highest priority. In the redirect cycle: inst_valid forced 0, pop suppressed, mem_req=0, count<=0, head_pc<=redirect_addr&~1, fetch_addr<=redirect_addr&~3, skip_low<=redirect_addr[1].
- Redirect latency: redirect at t -> mem_req at t+1 -> rvalid at t+2 -> inst_valid at t+3.
- Full queue: no issue. Credit accounting must prevent overflow. A 32-bit instruction with only its first halfword buffered holds inst_valid=0.
- Reset mid-operation: everything returns to reset values next edge; a response arriving after reset is ignored (state S_IDLE, no inflight).

Decomposition:
- Package thumb_fetch_pkg: state enum {S_IDLE, S_RUN, S_DROP}; function is_thumb32(halfword); constants HW_BYTES=2, WORD_BYTES=4.
- Sub-module halfword_fifo:
  - parametrised by BUF_DEPTH.
  - push of 0/1/2 halfwords, pop of 0/1/2, flush.
  - exposes head0, head1, count.

Test Plan:
- Reset with RESET_PC=0; ROM words 0x2001_4608, 0x4770_3001 -> inst at pc 0 data 0x4608_0000 is32=0, then pc 2 0x2001, pc 4 0x3001, pc 6 0x4770.
- Mixed 32-bit: word 0 = 0xF800_F000 -> inst_pc=0, inst_data=0xF000_F800, inst_is32=1, next inst_pc=4.
- 32-bit instruction straddling words: prefix halfword at 0x6 -> inst_valid stays 0 until the word at 0x8 arrives; then inst_pc=6, is32=1.
- Redirect to 0x0012 with a request in flight:
  - in-flight data is discarded.
  - mem_addr=0x0010 at t+1.
  - first inst_pc=0x0012 at t+3.
  - the halfword at 0x10 is never presented.
- Backpressure: hold inst_ready=0 with BUF_DEPTH=8 -> mem_req stops with count=8, no overflow; releasing ready resumes in-order delivery with no gaps or duplicates.
- Address wrap: RESET_PC=0xFFFC, ADDR_W=16 -> fetches 0xFFFC then 0x0000; inst_pc sequence 0xFFFC, 0xFFFE, 0x0000.

Source files
------------

// File: rtl/thumb_fetch_pkg.sv
// rtl/thumb_fetch_pkg.sv - shared types and helpers for the Thumb fetch front-end
package thumb_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DROP
    } fetch_state_t;

    localparam int HW_BYTES   = 2;
    localparam int WORD_BYTES = 4;

    // A Thumb-2 32-bit encoding is flagged by the top five bits of its first halfword.
    function automatic logic is_thumb32(input logic [15:0] hw);
        return hw[15:11] inside {5'b11101, 5'b11110, 5'b11111};
    endfunction

endpackage

// File: rtl/halfword_fifo.sv
// rtl/halfword_fifo.sv - circular halfword queue with 0/1/2 push and pop per cycle
module halfword_fifo #(
    parameter int BUF_DEPTH = 8,
    localparam int PTR_W = $clog2(BUF_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       push_cnt,
    input  logic [15:0]      push_data0,
    input  logic [15:0]      push_data1,
    input  logic [1:0]       pop_cnt,
    output logic [15:0]      head0,
    output logic [15:0]      head1,
    output logic [CNT_W-1:0] count
);

    logic [15:0]      mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        end
    end

    // Storage carries no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= push_data0;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr + PTR_W'(1)] <= push_data1;
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/thumb_fetch_unit.sv
// rtl/thumb_fetch_unit.sv - word-fetching Thumb instruction front-end with prefetch queue and redirect
module thumb_fetch_unit
    import thumb_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                BUF_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic              inst_is32,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int                CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] HW_STEP   = ADDR_W'(HW_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] head_pc;
    logic              skip_low;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [15:0]       head0;
    logic [15:0]       head1;
    logic              head32;
    logic              accept;
    logic              pop;
    logic              has_credit;
    logic [1:0]        push_cnt;
    logic [1:0]        pop_cnt;
    logic [15:0]       push_data0;
    logic [15:0]       push_data1;

    halfword_fifo #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push_cnt  (push_cnt),
        .push_data0(push_data0),
        .push_data1(push_data1),
        .pop_cnt   (pop_cnt),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    assign head32     = is_thumb32(head0);
    assign inst_valid = !redirect_valid &&
                        ((count >= CNT_W'(2)) || ((count == CNT_W'(1)) && !head32));
    assign inst_is32  = head32;
    assign inst_data  = head32 ? {head0, head1} : {head0, 16'h0000};
    assign inst_pc    = head_pc;
    assign pop        = inst_valid && inst_ready;
    assign pop_cnt    = !pop ? 2'd0 : (head32 ? 2'd2 : 2'd1);

    // Reserve room for the response already on its way before committing to another word.
    assign has_credit = (int'(count) + 2 * int'(inflight) + 2) <= BUF_DEPTH;
    assign mem_req    = (state != S_IDLE) && fetch_en && !redirect_valid && has_credit;
    assign mem_addr   = fetch_addr;

    // A response is only ours if we asked for it last cycle and nothing has since flushed it.
    assign accept = mem_rvalid && inflight && (state != S_DROP) && !redirect_valid;

    always_comb begin
        push_cnt   = 2'd0;
        push_data0 = mem_rdata[15:0];
        push_data1 = mem_rdata[31:16];
        if (accept) begin
            if (skip_low) begin
                push_cnt   = 2'd1;
                push_data0 = mem_rdata[31:16];
            end else begin
                push_cnt = 2'd2;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = inflight ? S_DROP : (fetch_en ? S_RUN : S_IDLE);
        end else begin
            case (state)
                S_IDLE:  if (fetch_en) state_next = S_RUN;
                S_RUN:   if (!fetch_en && !inflight) state_next = S_IDLE;
                S_DROP:  state_next = fetch_en ? S_RUN : S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            inflight   <= 1'b0;
            fetch_addr <= RESET_PC & ~ADDR_W'(3);
            head_pc    <= RESET_PC & ~ADDR_W'(1);
            skip_low   <= RESET_PC[1];
        end else begin
            state    <= state_next;
            inflight <= mem_req;
            if (redirect_valid) begin
                fetch_addr <= redirect_addr & ~ADDR_W'(3);
                head_pc    <= redirect_addr & ~ADDR_W'(1);
                skip_low   <= redirect_addr[1];
            end else begin
                if (mem_req) begin
                    fetch_addr <= fetch_addr + WORD_STEP;
                end
                if (pop) begin
                    head_pc <= head_pc + (head32 ? WORD_STEP : HW_STEP);
                end
                if (accept && skip_low) begin
                    skip_low <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_thumb_fetch_unit.sv
// tb/tb_thumb_fetch_unit.sv - self-checking bench for thumb_fetch_unit against a ROM-walk reference model
module tb_thumb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        fetch_en = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic        inst_is32;
    logic [15:0] inst_pc;

    logic        w_fetch_en = 1'b0;
    logic        w_mem_req;
    logic [15:0] w_mem_addr;
    logic [31:0] w_mem_rdata = '0;
    logic        w_mem_rvalid = 1'b0;
    logic        w_redirect_valid = 1'b0;
    logic [15:0] w_redirect_addr = '0;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b0;
    logic [31:0] w_inst_data;
    logic        w_inst_is32;
    logic [15:0] w_inst_pc;

    logic [31:0] rom [16384];

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] data;
        logic        is32;
    } inst_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_hs = 0;
    logic [15:0] exp_pc = '0;
    inst_t       dir_q[$];
    inst_t       w_inst_q[$];
    logic [15:0] w_addr_q[$];

    thumb_fetch_unit #(.ADDR_W(16), .BUF_DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_is32(inst_is32), .inst_pc(inst_pc)
    );

    thumb_fetch_unit #(.ADDR_W(16), .BUF_DEPTH(8), .RESET_PC(16'hFFFC)) dut_w (
        .clk(clk), .rst(rst), .fetch_en(w_fetch_en),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata), .mem_rvalid(w_mem_rvalid),
        .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_data(w_inst_data),
        .inst_is32(w_inst_is32), .inst_pc(w_inst_pc)
    );

    // Single-cycle ROM: answers every request on the following edge.
    always @(posedge clk) begin
        mem_rvalid   <= mem_req;
        mem_rdata    <= rom[mem_addr[15:2]];
        w_mem_rvalid <= w_mem_req;
        w_mem_rdata  <= rom[w_mem_addr[15:2]];
    end

    function automatic logic [15:0] hw_at(input logic [15:0] a);
        logic [31:0] w;
        w = rom[a[15:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: the instruction that decode must see when it starts reading at pc.
    function automatic inst_t ref_inst(input logic [15:0] pc);
        inst_t       r;
        logic [15:0] h0;
        h0     = hw_at(pc);
        r.pc   = pc;
        r.is32 = (h0[15:11] >= 5'd29);
        r.data = r.is32 ? {h0, hw_at(pc + 16'd2)} : {h0, 16'h0000};
        return r;
    endfunction

    function automatic inst_t mk(input logic [15:0] pc, input logic [31:0] data, input logic is32);
        inst_t r;
        r.pc   = pc;
        r.data = data;
        r.is32 = is32;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        inst_t e;
        inst_t d;
        #1;
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            e = ref_inst(exp_pc);
            chk("inst_pc", 32'(inst_pc), 32'(e.pc));
            chk("inst_data", inst_data, e.data);
            chk("inst_is32", 32'(inst_is32), 32'(e.is32));
            if (dir_q.size() > 0) begin
                d = dir_q.pop_front();
                chk("dir_pc", 32'(inst_pc), 32'(d.pc));
                chk("dir_data", inst_data, d.data);
                chk("dir_is32", 32'(inst_is32), 32'(d.is32));
            end
            exp_pc = e.pc + (e.is32 ? 16'd4 : 16'd2);
            n_hs++;
        end
        @(negedge clk);
    endtask

    initial begin
        int          hs_start;
        logic [15:0] hw;
        logic [15:0] hw2;
        inst_t       e;

        for (int i = 0; i < 16384; i++) begin
            hw  = 16'($urandom);
            hw2 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) hw[15:11] = 5'd29 + 5'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) hw2[15:11] = 5'd29 + 5'($urandom_range(0, 2));
            rom[i] = {hw2, hw};
        end
        rom[0] = 32'h2001_4608;
        rom[1] = 32'h4770_3001;

        // Reset state, then the first in-order stream from address 0
        @(negedge clk);
        tick();
        tick();
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        chk("reset_inst_pc", 32'(inst_pc), 32'h0000);
        chk("reset_count", 32'(dut.u_fifo.count), 32'd0);
        rst = 1'b0;
        fetch_en = 1'b1;
        inst_ready = 1'b1;
        exp_pc = 16'h0000;
        dir_q.push_back(mk(16'h0000, 32'h4608_0000, 1'b0));
        dir_q.push_back(mk(16'h0002, 32'h2001_0000, 1'b0));
        dir_q.push_back(mk(16'h0004, 32'h3001_0000, 1'b0));
        dir_q.push_back(mk(16'h0006, 32'h4770_0000, 1'b0));
        repeat (12) tick();
        chk("first_stream_done", 32'(dir_q.size()), 32'd0);

        // 32-bit instruction inside a single word
        redirect_valid = 1'b1;
        redirect_addr = 16'h0000;
        exp_pc = 16'h0000;
        rom[0] = 32'hF800_F000;
        dir_q.push_back(mk(16'h0000, 32'hF000_F800, 1'b1));
        dir_q.push_back(mk(16'h0004, 32'h3001_0000, 1'b0));
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();
        chk("mixed32_done", 32'(dir_q.size()), 32'd0);

        // 32-bit instruction straddling two words
        redirect_valid = 1'b1;
        redirect_addr = 16'h0006;
        exp_pc = 16'h0006;
        rom[1] = 32'hF000_3001;
        rom[2] = 32'h1234_F800;
        dir_q.push_back(mk(16'h0006, 32'hF000_F800, 1'b1));
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        #1 chk("straddle_hold", 32'(inst_valid), 32'd0);
        tick();
        #1 chk("straddle_valid", 32'(inst_valid), 32'd1);
        tick();
        chk("straddle_done", 32'(dir_q.size()), 32'd0);

        // Redirect to 0x12 while a word request is in flight
        redirect_valid = 1'b1;
        redirect_addr = 16'h0004;
        exp_pc = 16'h0004;
        rom[4] = 32'h2123_BEEF;
        tick();
        redirect_valid = 1'b0;
        #1 chk("inflight_req", 32'(mem_req), 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_addr = 16'h0012;
        exp_pc = 16'h0012;
        dir_q.push_back(mk(16'h0012, 32'h2123_0000, 1'b0));
        #1 chk("redirect_cycle_req", 32'(mem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redirect_t1_req", 32'(mem_req), 32'd1);
        chk("redirect_t1_addr", 32'(mem_addr), 32'h0010);
        chk("redirect_t1_valid", 32'(inst_valid), 32'd0);
        tick();
        #1 chk("redirect_t2_valid", 32'(inst_valid), 32'd0);
        tick();
        #1;
        chk("redirect_t3_valid", 32'(inst_valid), 32'd1);
        chk("redirect_t3_pc", 32'(inst_pc), 32'h0012);
        tick();
        chk("redirect_done", 32'(dir_q.size()), 32'd0);

        // Backpressure fills the queue exactly to depth and stops requests
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 16'h0100;
        exp_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        chk("full_mem_req", 32'(mem_req), 32'd0);
        chk("full_count", 32'(dut.u_fifo.count), 32'd8);

        // Random ready / fetch_en / redirects plus one mid-run reset
        hs_start = n_hs;
        for (int i = 0; i < 400; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            fetch_en = ($urandom_range(0, 15) != 0);
            redirect_valid = 1'b0;
            if (i == 200) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
                redirect_valid = 1'b1;
                redirect_addr = 16'($urandom);
                exp_pc = redirect_addr & 16'hFFFE;
            end
            #1;
            if (!fetch_en) chk("halt_no_req", 32'(mem_req), 32'd0);
            chk("count_bound", 32'(dut.u_fifo.count <= 8), 32'd1);
            tick();
            if (rst) begin
                chk("midrun_reset_req", 32'(mem_req), 32'd0);
                chk("midrun_reset_valid", 32'(inst_valid), 32'd0);
                rst = 1'b0;
                exp_pc = 16'h0000;
            end
        end
        redirect_valid = 1'b0;
        chk("random_progress", 32'((n_hs - hs_start) >= 100), 32'd1);

        // Fetch disabled: buffered instructions drain, no new requests
        fetch_en = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 chk("halt_req", 32'(mem_req), 32'd0);
            tick();
        end

        // Address wrap on the RESET_PC=0xFFFC instance
        rom[16383] = 32'h3002_2001;
        rst = 1'b1;
        w_fetch_en = 1'b1;
        w_inst_ready = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (w_mem_req) w_addr_q.push_back(w_mem_addr);
            if (w_inst_valid) w_inst_q.push_back(mk(w_inst_pc, w_inst_data, w_inst_is32));
            @(negedge clk);
        end
        chk("wrap_req_seen", 32'(w_addr_q.size() >= 2), 32'd1);
        chk("wrap_inst_seen", 32'(w_inst_q.size() >= 3), 32'd1);
        while (w_addr_q.size() < 2) w_addr_q.push_back(16'hDEAD);
        while (w_inst_q.size() < 3) w_inst_q.push_back(mk(16'hDEAD, 32'hDEAD_DEAD, 1'b0));
        chk("wrap_addr0", 32'(w_addr_q[0]), 32'hFFFC);
        chk("wrap_addr1", 32'(w_addr_q[1]), 32'h0000);
        chk("wrap_pc0", 32'(w_inst_q[0].pc), 32'hFFFC);
        chk("wrap_pc1", 32'(w_inst_q[1].pc), 32'hFFFE);
        chk("wrap_pc2", 32'(w_inst_q[2].pc), 32'h0000);
        e = ref_inst(16'hFFFC);
        chk("wrap_data0", w_inst_q[0].data, e.data);
        e = ref_inst(16'hFFFE);
        chk("wrap_data1", w_inst_q[1].data, e.data);
        e = ref_inst(16'h0000);
        chk("wrap_data2", w_inst_q[2].data, e.data);
        chk("wrap_is32_2", 32'(w_inst_q[2].is32), 32'(e.is32));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
